// File: rtl/cfg_pwm_timer.sv
// cfg_pwm_timer: register-mapped multi-channel edge-aligned PWM timer.
// Period/duty are double-buffered in shadow registers that reload only at a
// period wrap (or continuously while the timer is stopped or cleared).
// Optional centre-aligned counting is compiled in with the macro
// CFG_PWM_CENTER_ALIGNED_EN (control bit2 then selects it at run time).
module cfg_pwm_timer #(
  parameter  int NUM_CH    = 4,
  parameter  int REG_WIDTH = 8,
  localparam int CFG_BYTES = 2 + NUM_CH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic [CFG_BYTES*REG_WIDTH-1:0] config_regs,
  output logic [4*REG_WIDTH-1:0]         status_regs,
  output logic [NUM_CH-1:0]              pwm_out
);

  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

`ifdef CFG_PWM_CENTER_ALIGNED_EN
  localparam logic CA_BUILT = 1'b1;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir_q, dir_d;
  logic ca_c;
`else
  localparam logic CA_BUILT = 1'b0;
`endif

  // Decoded configuration
  logic [7:0]           ctrl;
  logic                 en_c, clr_c, run_c;
  logic [3:0]           psc_c;
  logic [REG_WIDTH-1:0] period_cfg;
  logic [REG_WIDTH-1:0] duty_cfg [NUM_CH];
  logic                 unused_ctrl_bits;

  // State
  logic [3:0]           pre_q, pre_d;
  logic [REG_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           wrap_q, wrap_d;
  logic [REG_WIDTH-1:0] period_q, period_d;
  logic [REG_WIDTH-1:0] duty_q [NUM_CH];
  logic [REG_WIDTH-1:0] duty_d [NUM_CH];
  logic [NUM_CH-1:0]    pwm_q, pwm_d;

  logic tick, wrap_ev, load, duty_gt;

  // Unpack the flattened configuration bus into control, period and duties
  always_comb begin
    ctrl       = config_regs[7:0];
    en_c       = ctrl[0];
    clr_c      = ctrl[1];
    psc_c      = ctrl[7:4];
    run_c      = en_c && !clr_c;
    period_cfg = config_regs[REG_WIDTH +: REG_WIDTH];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      duty_cfg[i] = config_regs[(2 + i) * REG_WIDTH +: REG_WIDTH];
    end
`ifdef CFG_PWM_CENTER_ALIGNED_EN
    ca_c             = ctrl[2];
    unused_ctrl_bits = ctrl[3];
`else
    unused_ctrl_bits = ^ctrl[3:2];
`endif
  end

  // Next-state: prescaler, counter, wrap count, shadow reload, PWM compare
  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    wrap_d   = wrap_q;
    period_d = period_q;
    duty_d   = duty_q;
    tick     = 1'b0;
    wrap_ev  = 1'b0;
    load     = 1'b0;
`ifdef CFG_PWM_CENTER_ALIGNED_EN
    dir_d    = dir_q;
`endif

    // Compare uses the current count, so the output lags cnt by one clock
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = run_c && (cnt_q < duty_q[i]);
    end

    if (clr_c) begin
      pre_d  = '0;
      cnt_d  = '0;
      wrap_d = '0;
      load   = 1'b1;
`ifdef CFG_PWM_CENTER_ALIGNED_EN
      dir_d  = DIR_UP;
`endif
    end else if (!en_c) begin
      pre_d  = '0;
      cnt_d  = '0;
      load   = 1'b1;
`ifdef CFG_PWM_CENTER_ALIGNED_EN
      dir_d  = DIR_UP;
`endif
    end else begin
      tick  = (pre_q == psc_c);
      pre_d = tick ? 4'd0 : pre_q + 4'd1;
      if (tick) begin
`ifdef CFG_PWM_CENTER_ALIGNED_EN
        if (ca_c && (period_q != '0)) begin
          // The wrap fires on the tick that lands on zero while descending,
          // so 0 is visited once per cycle and a period spans 2*period ticks.
          if ((dir_q == DIR_UP) && (cnt_q != period_q)) begin
            cnt_d = cnt_q + ONE;
          end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
              wrap_ev = 1'b1;
              dir_d   = DIR_UP;
            end else begin
              dir_d   = DIR_DOWN;
            end
          end
        end else begin
          dir_d = DIR_UP;
          if (cnt_q == period_q) begin
            cnt_d   = '0;
            wrap_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
`else
        if (cnt_q == period_q) begin
          cnt_d   = '0;
          wrap_ev = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
`endif
      end
      if (wrap_ev) begin
        wrap_d = wrap_q + 8'd1;
        load   = 1'b1;
      end
    end

    if (load) begin
      period_d = period_cfg;
      duty_d   = duty_cfg;
    end
  end

  // State registers: reset beats the global enable, which freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= '0;
      period_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
      pwm_q    <= '0;
`ifdef CFG_PWM_CENTER_ALIGNED_EN
      dir_q    <= DIR_UP;
`endif
    end else if (ena) begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      period_q <= period_d;
      for (int unsigned i = 0; i < NUM_CH; i++) duty_q[i] <= duty_d[i];
      pwm_q    <= pwm_d;
`ifdef CFG_PWM_CENTER_ALIGNED_EN
      dir_q    <= dir_d;
`endif
    end
  end

  // Status bus assembled straight from registers and live control bits
  always_comb begin
    duty_gt = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (duty_q[i] > period_q) duty_gt = 1'b1;
    end
    status_regs                         = '0;
    status_regs[0 +: REG_WIDTH]         = cnt_q;
    status_regs[REG_WIDTH +: 8]         = wrap_q;
    status_regs[2*REG_WIDTH +: NUM_CH]  = pwm_q;
    status_regs[3*REG_WIDTH]            = run_c;
    status_regs[3*REG_WIDTH + 1]        = duty_gt;
    status_regs[3*REG_WIDTH + 2]        = CA_BUILT;
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_cfg_pwm_timer.sv
// Self-checking bench for cfg_pwm_timer: directed steps plus randomized
// configuration traffic, compared every cycle against a phase-based model.
module tb_cfg_pwm_timer;

  localparam int NUM_CH = 4;
  localparam int RW     = 8;
`ifdef CFG_PWM_CENTER_ALIGNED_EN
  localparam bit CA_BUILT = 1'b1;
`else
  localparam bit CA_BUILT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, ena;
  logic [7:0]        ctrl, period;
  logic [7:0]        duty [NUM_CH];
  logic [(2+NUM_CH)*RW-1:0] config_regs;
  logic [4*RW-1:0]   status_regs;
  logic [NUM_CH-1:0] pwm_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the current period plus shadows
  int        m_pres, m_pos, m_wrap, m_period;
  int        m_duty [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;

  assign config_regs = {duty[3], duty[2], duty[1], duty[0], period, ctrl};

  always #5 clk = ~clk;

  cfg_pwm_timer #(.NUM_CH(NUM_CH), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .config_regs(config_regs),
    .status_regs(status_regs), .pwm_out(pwm_out)
  );

  function automatic bit ca_on();
    return CA_BUILT && ctrl[2];
  endfunction

  function automatic int period_len(int p, bit ca);
    if (!ca) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  // Counter value seen at a given phase: ramp in edge mode, triangle in CA
  function automatic int cnt_of(int pos, int p, bit ca);
    if (!ca || p == 0) return pos;
    return (pos <= p) ? pos : 2 * p - pos;
  endfunction

  task automatic load_shadows();
    m_period = period;
    for (int c = 0; c < NUM_CH; c++) m_duty[c] = duty[c];
  endtask

  task automatic model_step();
    bit en, clr, ca;
    int psc, c;
    logic [NUM_CH-1:0] np;
    en  = ctrl[0];
    clr = ctrl[1];
    psc = ctrl[7:4];
    ca  = ca_on();
    if (rst) begin
      m_pres = 0; m_pos = 0; m_wrap = 0; m_period = 0; m_pwm = '0;
      for (int k = 0; k < NUM_CH; k++) m_duty[k] = 0;
    end else if (ena) begin
      c = cnt_of(m_pos, m_period, ca);
      for (int k = 0; k < NUM_CH; k++) np[k] = en && !clr && (c < m_duty[k]);
      if (clr) begin
        m_pres = 0; m_pos = 0; m_wrap = 0; load_shadows();
      end else if (!en) begin
        m_pres = 0; m_pos = 0; load_shadows();
      end else if (m_pres == psc) begin
        m_pres = 0;
        m_pos  = (m_pos + 1) % period_len(m_period, ca);
        if (m_pos == 0) begin
          m_wrap = (m_wrap + 1) % 256;
          load_shadows();
        end
      end else begin
        m_pres = (m_pres + 1) % 16;
      end
      m_pwm = np;
    end
  endtask

  task automatic check_outputs(string tag);
    logic [31:0] es;
    bit gt;
    gt = 1'b0;
    for (int k = 0; k < NUM_CH; k++) if (m_duty[k] > m_period) gt = 1'b1;
    es = {5'd0, CA_BUILT, gt, ctrl[0] && !ctrl[1],
          {(8-NUM_CH){1'b0}}, m_pwm,
          m_wrap[7:0],
          8'(cnt_of(m_pos, m_period, ca_on()))};
    checks++;
    assert (status_regs === es) else begin
      failures++;
      $error("FAIL %s status_regs observed=%h expected=%h t=%0t", tag, status_regs, es, $time);
    end
    checks++;
    assert (pwm_out === m_pwm) else begin
      failures++;
      $error("FAIL %s pwm_out observed=%b expected=%b t=%0t", tag, pwm_out, m_pwm, $time);
    end
  endtask

  task automatic cyc(string tag, int n = 1);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
      check_outputs(tag);
    end
  endtask

  task automatic count_high(string tag, int ch, int window, int want);
    int hi;
    hi = 0;
    repeat (window) begin
      cyc(tag);
      hi += int'(pwm_out[ch]);
    end
    checks++;
    assert (hi == want) else begin
      failures++;
      $error("FAIL %s high_cycles observed=%0d expected=%0d", tag, hi, want);
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; ena = 1'b1;
    ctrl = 8'hFF; period = 8'hFF;
    for (int k = 0; k < NUM_CH; k++) duty[k] = 8'hFF;

    // 1. Reset with config all ones, then basic run
    cyc("reset", 2);
    checks++;
    assert (status_regs === 32'h0) else begin
      failures++;
      $error("FAIL reset_zero status_regs observed=%h expected=%h", status_regs, 32'h0);
    end
    rst = 1'b0;
    ctrl = 8'h00; period = 8'd9;
    duty[0] = 8'd3; duty[1] = 8'd0; duty[2] = 8'd0; duty[3] = 8'd0;
    cyc("stop_load");
    ctrl = 8'h01;
    cyc("basic", 12);
    count_high("basic_duty", 0, 10, 3);
    cyc("basic", 20);

    // 2. Prescaler and global-enable freeze
    ctrl = 8'h31; period = 8'd4; duty[1] = 8'd2;
    cyc("psc", 30);
    count_high("psc_duty", 1, 20, 8);
    cyc("psc", 7);
    ena = 1'b0;
    cyc("ena_low", 5);
    ena = 1'b1;
    cyc("ena_resume", 30);

    // 3. Double buffering: mid-period write, then write on the wrap edge
    ctrl = 8'h03; period = 8'd9; duty[0] = 8'd3; duty[1] = 8'd0;
    cyc("dbuf_clr");
    ctrl = 8'h01;
    cyc("dbuf", 3);
    duty[0] = 8'd7;
    cyc("dbuf_mid", 25);
    guard = 0;
    while (m_pos != 9 && guard < 20) begin
      cyc("dbuf_seek");
      guard++;
    end
    checks++;
    assert (guard < 20) else begin
      failures++;
      $error("FAIL dbuf_seek cycles observed=%0d expected<20", guard);
    end
    duty[0] = 8'd2;
    cyc("dbuf_wrapedge", 25);

    // 4. Boundaries: zero duty, duty above period, period zero, wrap rollover
    duty[2] = 8'd0; duty[3] = 8'd12;
    cyc("bound_duty", 25);
    period = 8'd0; duty[0] = 8'd1;
    cyc("period0", 300);

    // 5. CLR mid-period then EN drop
    period = 8'd9; duty[0] = 8'd3;
    cyc("clr_en", 15);
    ctrl = 8'h03;
    cyc("clr", 2);
    ctrl = 8'h01;
    cyc("clr_release", 5);
    ctrl = 8'h00;
    cyc("en_low", 3);

`ifdef CFG_PWM_CENTER_ALIGNED_EN
    // 6. Centre-aligned mode
    ctrl = 8'h02; period = 8'd4; duty[0] = 8'd2;
    cyc("ca_clr");
    ctrl = 8'h05;
    cyc("ca", 30);
    period = 8'd1;
    cyc("ca_p1", 12);
    ctrl = 8'h00;
    cyc("ca_stop");
`endif

    // Randomized configuration traffic in edge mode
    ctrl = 8'h01;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        ctrl = {4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0)};
        period = 8'($urandom_range(0, 15));
        for (int k = 0; k < NUM_CH; k++) duty[k] = 8'($urandom_range(0, 20));
      end
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
